// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised progressive raster timing generator.
// Produces pixel/line position counters together with registered DE, sync,
// HDMI video preamble/guard-band windows, line/frame strobes and a frame
// counter. Every flag decodes the same position as the counters that are
// output in the same cycle. Positions are computed one step ahead, and flags
// are decoded from that next position before both are registered together.
module video_timing_gen #(
  parameter int H_ACTIVE        = 720,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 62,
  parameter int H_BACK          = 60,
  parameter int V_ACTIVE        = 480,
  parameter int V_FRONT         = 9,
  parameter int V_SYNC          = 6,
  parameter int V_BACK          = 30,
  parameter int H_SYNC_POL      = 0,
  parameter int V_SYNC_POL      = 0,
  parameter int CNT_WIDTH       = 12,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic                       pixelClock,
  input  logic                       reset,
  input  logic                       enable,
  output logic [CNT_WIDTH-1:0]       hPosCounter,
  output logic [CNT_WIDTH-1:0]       vPosCounter,
  output logic                       inActiveDisplay,
  output logic                       hSync,
  output logic                       vSync,
  output logic                       videoPreamble,
  output logic                       videoGuard,
  output logic                       lineStart,
  output logic                       frameStart,
  output logic [FRAME_CNT_WIDTH-1:0] frameCount
);

  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_ACTIVE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  typedef logic [CNT_WIDTH-1:0] pos_t;

  localparam pos_t H_LAST       = pos_t'(H_TOTAL - 1);
  localparam pos_t V_LAST       = pos_t'(V_TOTAL - 1);
  localparam pos_t H_ACT_P      = pos_t'(H_ACTIVE);
  localparam pos_t V_ACT_P      = pos_t'(V_ACTIVE);
  localparam pos_t V_PRE_LAST   = pos_t'(V_ACTIVE - 1);
  localparam pos_t HS_START_P   = pos_t'(HS_START);
  localparam pos_t HS_END_P     = pos_t'(HS_END);
  localparam pos_t VS_START_P   = pos_t'(VS_START);
  localparam pos_t VS_END_P     = pos_t'(VS_END);
  localparam pos_t PRE_START_P  = pos_t'(H_TOTAL - 10);
  localparam pos_t PRE_END_P    = pos_t'(H_TOTAL - 3);
  localparam pos_t GUARD_STRT_P = pos_t'(H_TOTAL - 2);

  localparam logic H_POL = (H_SYNC_POL != 0);
  localparam logic V_POL = (V_SYNC_POL != 0);

  // Illegal geometries are rejected at elaboration.
  if (H_BACK < 10) begin : g_bad_h_back
    $error("video_timing_gen: H_BACK must be >= 10 to fit preamble and guard band");
  end
  if (V_ACTIVE < 1) begin : g_bad_v_active
    $error("video_timing_gen: V_ACTIVE must be >= 1");
  end
  if (((H_TOTAL - 1) >> CNT_WIDTH) != 0 || ((V_TOTAL - 1) >> CNT_WIDTH) != 0) begin : g_bad_width
    $error("video_timing_gen: CNT_WIDTH too narrow for H_TOTAL-1 / V_TOTAL-1");
  end

  // Sync fields hold the output pin level, so polarity is already applied.
  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    logic preamble;
    logic guard;
  } flags_t;

  // Reset parks the raster on the last pixel of the frame; these are the
  // flags that position decodes to, so the first enabled edge lands on (0,0).
  localparam flags_t FLAGS_RST = '{de: 1'b0, hsync: ~H_POL, vsync: ~V_POL,
                                   preamble: 1'b0, guard: 1'b1};

  pos_t                       r_h_pos;
  pos_t                       r_v_pos;
  flags_t                     r_flags;
  logic                       r_line_start;
  logic                       r_frame_start;
  logic [FRAME_CNT_WIDTH-1:0] r_frame_count;

  logic   w_h_wrap;
  logic   w_v_wrap;
  pos_t   w_next_h;
  pos_t   w_next_v;
  logic   w_pre_active;
  logic   w_hs_active;
  logic   w_vs_active;
  logic   w_to_origin;
  flags_t w_flags;

  assign w_h_wrap    = (r_h_pos == H_LAST);
  assign w_v_wrap    = (r_v_pos == V_LAST);
  assign w_next_h    = w_h_wrap ? '0 : r_h_pos + 1'b1;
  assign w_next_v    = w_h_wrap ? (w_v_wrap ? '0 : r_v_pos + 1'b1) : r_v_pos;
  assign w_to_origin = (w_next_h == '0) && (w_next_v == '0);

  // Decode the flags for the position the counters move to on the next edge.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    w_flags      = FLAGS_RST;
    w_pre_active = (w_next_v == V_LAST) || (w_next_v < V_PRE_LAST);
    w_hs_active  = (w_next_h >= HS_START_P) && (w_next_h < HS_END_P);
    // vSync spans from the hSync leading edge of line VS_START to the hSync
    // leading edge of line VS_END.
    w_vs_active  = ((w_next_v == VS_START_P) && (w_next_h >= HS_START_P)) ||
                   ((w_next_v >  VS_START_P) && (w_next_v <  VS_END_P))   ||
                   ((w_next_v == VS_END_P)   && (w_next_h <  HS_START_P));

    w_flags.de       = (w_next_h < H_ACT_P) && (w_next_v < V_ACT_P);
    w_flags.hsync    = w_hs_active ? H_POL : ~H_POL;
    w_flags.vsync    = w_vs_active ? V_POL : ~V_POL;
    w_flags.preamble = w_pre_active && (w_next_h >= PRE_START_P) && (w_next_h <= PRE_END_P);
    w_flags.guard    = w_pre_active && (w_next_h >= GUARD_STRT_P);
  end

  // Advance position and flags together while enabled; strobes only fire on an enabled edge.
  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      r_h_pos       <= H_LAST;
      r_v_pos       <= V_LAST;
      r_flags       <= FLAGS_RST;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, as real flops do.
      r_line_start  <= enable && (w_next_h == '0);
      r_frame_start <= enable && w_to_origin;
      if (enable) begin
        r_h_pos <= w_next_h;
        r_v_pos <= w_next_v;
        r_flags <= w_flags;
        if (w_to_origin) begin
          r_frame_count <= r_frame_count + 1'b1;
        end
      end
    end
  end

  assign hPosCounter     = r_h_pos;
  assign vPosCounter     = r_v_pos;
  assign inActiveDisplay = r_flags.de;
  assign hSync           = r_flags.hsync;
  assign vSync           = r_flags.vsync;
  assign videoPreamble   = r_flags.preamble;
  assign videoGuard      = r_flags.guard;
  assign lineStart       = r_line_start;
  assign frameStart      = r_frame_start;
  assign frameCount      = r_frame_count;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: drives a reduced raster (40x18 total) with directed and
// random enable patterns and compares every output each cycle against a
// linear-pixel-index reference model.
module tb_video_timing_gen;

  localparam int HA = 20, HF = 4, HS = 5, HB = 11;
  localparam int VA = 10, VF = 2, VS = 3, VB = 3;
  localparam int H_POL = 1, V_POL = 0;
  localparam int CW = 6, FCW = 2;
  localparam int HT = HA + HF + HS + HB;   // 40
  localparam int VT = VA + VF + VS + VB;   // 18
  localparam int FRAME = HT * VT;          // 720

  logic           pixelClock = 1'b0;
  logic           reset;
  logic           enable;
  logic [CW-1:0]  hPosCounter, vPosCounter;
  logic           inActiveDisplay, hSync, vSync, videoPreamble, videoGuard;
  logic           lineStart, frameStart;
  logic [FCW-1:0] frameCount;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: raster position as one linear pixel index within the frame.
  int m_idx;
  int m_frames;
  bit m_ls, m_fs;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(H_POL), .V_SYNC_POL(V_POL),
    .CNT_WIDTH(CW), .FRAME_CNT_WIDTH(FCW)
  ) dut (
    .pixelClock(pixelClock), .reset(reset), .enable(enable),
    .hPosCounter(hPosCounter), .vPosCounter(vPosCounter),
    .inActiveDisplay(inActiveDisplay), .hSync(hSync), .vSync(vSync),
    .videoPreamble(videoPreamble), .videoGuard(videoGuard),
    .lineStart(lineStart), .frameStart(frameStart), .frameCount(frameCount)
  );

  always #5 pixelClock = ~pixelClock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_idx = FRAME - 1; m_frames = 0; m_ls = 0; m_fs = 0;
  endtask

  task automatic model_edge();
    if (reset) model_reset();
    else if (enable) begin
      m_idx = (m_idx + 1) % FRAME;
      m_ls  = (m_idx % HT) == 0;
      m_fs  = (m_idx == 0);
      if (m_fs) m_frames++;
    end else begin
      m_ls = 0; m_fs = 0;
    end
  endtask

  task automatic check_all();
    int  h, v, vs_lo, vs_hi;
    bit  hs_act, vs_act, pre_line;
    h        = m_idx % HT;
    v        = m_idx / HT;
    hs_act   = (h >= HA + HF) && (h < HA + HF + HS);
    vs_lo    = (VA + VF) * HT + HA + HF;
    vs_hi    = (VA + VF + VS) * HT + HA + HF;
    vs_act   = (m_idx >= vs_lo) && (m_idx < vs_hi);
    pre_line = ((v + 1) % VT) < VA;   // the following line is active
    check("hpos",   32'(hPosCounter),     32'(h));
    check("vpos",   32'(vPosCounter),     32'(v));
    check("de",     32'(inActiveDisplay), 32'(h < HA && v < VA));
    check("hsync",  32'(hSync),           32'(hs_act ? H_POL : 1 - H_POL));
    check("vsync",  32'(vSync),           32'(vs_act ? V_POL : 1 - V_POL));
    check("pre",    32'(videoPreamble),   32'(pre_line && h >= HT - 10 && h <= HT - 3));
    check("guard",  32'(videoGuard),      32'(pre_line && h >= HT - 2));
    check("lstart", 32'(lineStart),       32'(m_ls));
    check("fstart", 32'(frameStart),      32'(m_fs));
    check("fcount", 32'(frameCount),      32'(m_frames % (1 << FCW)));
  endtask

  task automatic step();
    @(posedge pixelClock);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int cycles;
    reset  = 1'b1;
    enable = 1'b0;
    model_reset();

    // Reset state (guard band high on the parked last pixel).
    repeat (3) step();
    check("rst_guard", 32'(videoGuard), 32'd1);

    // Release away from the edge; a disabled edge keeps reset values.
    reset = 1'b0;
    step();

    // First enabled edge: origin with both strobes and frameCount = 1.
    enable = 1'b1;
    step();
    check("first_h",  32'(hPosCounter), 32'd0);
    check("first_fs", 32'(frameStart),  32'd1);

    // Frame period with enable held high.
    cycles = 0;
    do begin step(); cycles++; end while (!frameStart && cycles < 3 * FRAME);
    check("period", 32'(cycles), 32'(FRAME));

    // Pause 100 cycles at hPos 15 of line 3; period stretches by 100.
    cycles = 0;
    repeat (3 * HT + 15) begin step(); cycles++; end
    enable = 1'b0;
    repeat (100) begin step(); cycles++; end
    check("pause_h", 32'(hPosCounter), 32'd15);
    enable = 1'b1;
    step(); cycles++;
    check("resume_h", 32'(hPosCounter), 32'd16);
    while (!frameStart && cycles < 3 * FRAME) begin step(); cycles++; end
    check("pause_period", 32'(cycles), 32'(FRAME + 100));

    // Random enable pattern; frameCount wraps during this phase.
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      step();
    end

    // Asynchronous reset mid-frame, observed before any clock edge.
    enable = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (3) step();
    reset = 1'b0;
    step();
    check("post_rst_h",  32'(hPosCounter), 32'd0);
    check("post_rst_v",  32'(vPosCounter), 32'd0);
    check("post_rst_fs", 32'(frameStart),  32'd1);

    for (int i = 0; i < 1500; i++) begin
      enable = ($urandom_range(0, 7) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
